// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter
//   Shares one single-port unified memory between instruction fetch (IF) and
//   the load/store unit (LS). One requester is granted at a time. The memory
//   request is held stable until mem_ack. Read data comes back through
//   registered rdata outputs with a one-cycle valid pulse. A fetch response
//   is discarded when the pipeline redirects (if_flush).
//
//   Ports
//     clk, rst              rising-edge clock, async active-high reset
//     if_req/if_addr        fetch request (word aligned on the memory side)
//     if_flush              redirect pulse, cancels the fetch in flight
//     if_rdata/if_valid     fetched instruction and its one-cycle valid
//     if_stall              combinational fetch stall (if_req & ~if_valid)
//     ls_req/we/be/addr/wdata  load/store request, held until ls_valid
//     ls_rdata/ls_valid     load data (unchanged on writes) and completion
//     mem_req/we/be/addr/wdata  registered memory request
//     mem_rdata/mem_ack     memory response, honoured only while mem_req=1
//
//   Build option
//     STARVE_GUARD_EN  When this macro is defined, a counter tracks the LS
//                      grants made while fetch waits. After STARVE_MAX such
//                      grants, fetch wins the next contended arbitration.
//                      When it is undefined, LS has strict priority.

module imem_dmem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    input  logic            if_flush,
    output logic [DW-1:0]   if_rdata,
    output logic            if_valid,
    output logic            if_stall,
    input  logic            ls_req,
    input  logic            ls_we,
    input  logic [DW/8-1:0] ls_be,
    input  logic [AW-1:0]   ls_addr,
    input  logic [DW-1:0]   ls_wdata,
    output logic [DW-1:0]   ls_rdata,
    output logic            ls_valid,
    output logic            mem_req,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            mem_ack
);

    localparam int BW = DW / 8;

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("STARVE_MAX must be in 1..15");
    end

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS} state_t;

    state_t          state_q, state_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [BW-1:0]   mem_be_q, mem_be_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DW-1:0]   if_rdata_q, if_rdata_d;
    logic [DW-1:0]   ls_rdata_q, ls_rdata_d;
    logic            if_valid_q, if_valid_d;
    logic            ls_valid_q, ls_valid_d;
    logic            drop_q, drop_d;

    logic            grant_if, grant_ls;
    logic            hold_off;
    logic            ack_seen;
    logic            starve_force;
    logic            unused_if_addr_lsbs;

    assign unused_if_addr_lsbs = ^if_addr[1:0];

`ifdef STARVE_GUARD_EN
    logic [3:0] starve_cnt_q, starve_cnt_d;

    assign starve_force = (starve_cnt_q == 4'(STARVE_MAX)) & if_req & ls_req;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!if_req || grant_if) begin
            starve_cnt_d = 4'd0;
        end else if (grant_ls && starve_cnt_q != 4'hF) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= 4'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign starve_force = 1'b0;
`endif

    // During a completion cycle the finisher's req is still the old,
    // now-served request. If the finisher keeps req high, treat it as a
    // fresh request. That request competes in the next cycle. Nobody is
    // granted in this cycle, so a held LS stream keeps its priority.
    assign hold_off = (if_valid_q & if_req) | (ls_valid_q & ls_req);
    assign ack_seen = mem_ack & mem_req_q;

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        if_valid_d  = 1'b0;
        ls_valid_d  = 1'b0;
        drop_d      = drop_q;
        grant_if    = 1'b0;
        grant_ls    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!hold_off) begin
                    if (ls_req && !starve_force) begin
                        grant_ls = 1'b1;
                    end else if (if_req) begin
                        grant_if = 1'b1;
                    end
                end
                if (grant_ls) begin
                    state_d     = BUSY_LS;
                    mem_req_d   = 1'b1;
                    mem_we_d    = ls_we;
                    mem_be_d    = ls_be;
                    mem_addr_d  = ls_addr;
                    mem_wdata_d = ls_wdata;
                end else if (grant_if) begin
                    state_d     = BUSY_IF;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_be_d    = '1;
                    mem_addr_d  = {if_addr[AW-1:2], 2'b00};
                    mem_wdata_d = '0;
                    drop_d      = if_flush;
                end
            end
            BUSY_IF: begin
                if (ack_seen) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    drop_d    = 1'b0;
                    // A flush arriving with the ack still cancels this response.
                    if (!(drop_q || if_flush)) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end else if (if_flush) begin
                    drop_d = 1'b1;
                end
            end
            BUSY_LS: begin
                if (ack_seen) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    ls_valid_d = 1'b1;
                    if (!mem_we_q) begin
                        ls_rdata_d = mem_rdata;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            ls_valid_q  <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
            if_valid_q  <= if_valid_d;
            ls_valid_q  <= ls_valid_d;
            drop_q      <= drop_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;
    assign if_valid  = if_valid_q;
    assign ls_valid  = ls_valid_q;
    assign if_stall  = if_req & ~if_valid_q;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
module tb_imem_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, if_valid, if_stall;
    logic [31:0] if_addr, if_rdata;
    logic        ls_req, ls_we, ls_valid;
    logic [3:0]  ls_be;
    logic [31:0] ls_addr, ls_wdata, ls_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_if_rdata;

    imem_dmem_arbiter #(.AW(32), .DW(32), .STARVE_MAX(2)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
        .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_rdata(ls_rdata), .ls_valid(ls_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic        is_ls;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_out;
    } vec_t;

    vec_t vecs[5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_req"},   mem_req,   0);
        check({tag, "_mem_we"},    mem_we,    0);
        check({tag, "_mem_be"},    mem_be,    0);
        check({tag, "_mem_addr"},  mem_addr,  0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_if_rdata"},  if_rdata,  0);
        check({tag, "_ls_rdata"},  ls_rdata,  0);
        check({tag, "_if_valid"},  if_valid,  0);
        check({tag, "_ls_valid"},  ls_valid,  0);
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        string t;
        t = $sformatf("vec%0d", idx);
        if (v.is_ls) begin
            ls_req = 1'b1; ls_we = v.we; ls_be = v.be; ls_addr = v.addr; ls_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        step();
        for (int k = 0; k <= v.delay; k++) begin
            check({t, "_mem_req"},  mem_req,  1);
            check({t, "_mem_addr"}, mem_addr, v.exp_addr);
            check({t, "_mem_be"},   mem_be,   v.exp_be);
            check({t, "_mem_we"},   mem_we,   v.is_ls & v.we);
            if (v.is_ls) check({t, "_mem_wdata"}, mem_wdata, v.wdata);
            else         check({t, "_if_stall"},  if_stall,  1);
            if (k == v.delay) begin
                mem_ack = 1'b1; mem_rdata = v.rdata;
            end else begin
                mem_rdata = 32'hDEAD_0000 + k;
            end
            step();
        end
        mem_ack = 1'b0;
        check({t, "_mem_req_done"}, mem_req, 0);
        if (v.is_ls) begin
            check({t, "_ls_valid"}, ls_valid, 1);
            check({t, "_if_valid"}, if_valid, 0);
            check({t, "_ls_rdata"}, ls_rdata, v.exp_out);
            ls_req = 1'b0;
        end else begin
            check({t, "_if_valid"}, if_valid, 1);
            check({t, "_ls_valid"}, ls_valid, 0);
            check({t, "_if_rdata"}, if_rdata, v.exp_out);
            check({t, "_if_stall_done"}, if_stall, 0);
            if_req = 1'b0;
        end
        step();
        check({t, "_if_valid_once"}, if_valid, 0);
        check({t, "_ls_valid_once"}, ls_valid, 0);
        check({t, "_idle"}, mem_req, 0);
    endtask

    initial begin
        bit exp_if;
        int waited;

        vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h0000_0013, 32'h0, 32'h0050_0093, 0,
                    32'h0000_0010, 4'hF, 32'h0050_0093};
        vecs[1] = '{1'b1, 1'b0, 4'hF, 32'h0000_0200, 32'h0, 32'hCAFE_F00D, 1,
                    32'h0000_0200, 4'hF, 32'hCAFE_F00D};
        vecs[2] = '{1'b1, 1'b1, 4'h3, 32'h0000_0100, 32'hDEAD_BEEF, 32'h1234_5678, 3,
                    32'h0000_0100, 4'h3, 32'hCAFE_F00D};
        vecs[3] = '{1'b0, 1'b0, 4'h0, 32'h0000_1006, 32'h0, 32'h0000_0013, 2,
                    32'h0000_1004, 4'hF, 32'h0000_0013};
        vecs[4] = '{1'b1, 1'b0, 4'h4, 32'h0000_0203, 32'h0, 32'hA5A5_0000, 0,
                    32'h0000_0203, 4'h4, 32'hA5A5_0000};

        rst = 1'b1;
        if_req = 0; if_addr = 0; if_flush = 0;
        ls_req = 0; ls_we = 0; ls_be = 0; ls_addr = 0; ls_wdata = 0;
        mem_rdata = 0; mem_ack = 0;
        #1;
        check_all_zero("reset");
        check("reset_if_stall", if_stall, 0);
        step(); step();
        rst = 1'b0;
        step();

        // A stray ack while nothing is requested must be ignored.
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        step();
        check("stray_ack_ls_valid", ls_valid, 0);
        check("stray_ack_if_valid", if_valid, 0);
        step();
        check("stray_ack_ls_valid2", ls_valid, 0);
        check("stray_ack_ls_rdata", ls_rdata, 0);
        mem_ack = 1'b0;
        step();

        foreach (vecs[i]) run_txn(vecs[i], i);
        exp_if_rdata = 32'h0000_0013;

        // Simultaneous requests: LS first, then IF right after ls_valid.
        if_req = 1'b1; if_addr = 32'h0000_0040;
        ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF; ls_addr = 32'h0000_0300;
        step();
        check("prio_ls_addr", mem_addr, 32'h0000_0300);
        check("prio_if_stall", if_stall, 1);
        mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
        step();
        mem_ack = 1'b0;
        check("prio_ls_valid", ls_valid, 1);
        check("prio_ls_rdata", ls_rdata, 32'h1111_1111);
        ls_req = 1'b0;
        step();
        check("prio_if_mem_req", mem_req, 1);
        check("prio_if_addr", mem_addr, 32'h0000_0040);
        mem_ack = 1'b1; mem_rdata = 32'h2222_2222;
        step();
        mem_ack = 1'b0;
        check("prio_if_valid", if_valid, 1);
        check("prio_if_rdata", if_rdata, 32'h2222_2222);
        exp_if_rdata = 32'h2222_2222;
        if_req = 1'b0;
        step();

        // Continuous LS stream with fetch pending.
        if_req = 1'b1; if_addr = 32'h0000_0080;
        ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF; ls_addr = 32'h0000_0400;
        for (int i = 0; i < 6; i++) begin
`ifdef STARVE_GUARD_EN
            exp_if = (i % 3 == 2);
`else
            exp_if = 1'b0;
`endif
            waited = 0;
            while (mem_req !== 1'b1 && waited < 6) begin
                step();
                waited++;
            end
            check($sformatf("stream%0d_grant", i), mem_req, 1);
            check($sformatf("stream%0d_addr", i), mem_addr,
                  exp_if ? 32'h0000_0080 : 32'h0000_0400);
            mem_ack = 1'b1; mem_rdata = 32'h0B0B_0B0B;
            step();
            mem_ack = 1'b0;
            check($sformatf("stream%0d_if_valid", i), if_valid, exp_if);
            check($sformatf("stream%0d_ls_valid", i), ls_valid, !exp_if);
        end
`ifdef STARVE_GUARD_EN
        exp_if_rdata = 32'h0B0B_0B0B;
`endif
        if_req = 1'b0; ls_req = 1'b0;
        step(); step();

        // Flush one cycle before the ack: response dropped, next fetch normal.
        if_req = 1'b1; if_addr = 32'h0000_0020;
        step();
        check("flush_mem_addr", mem_addr, 32'h0000_0020);
        if_flush = 1'b1;
        step();
        if_flush = 1'b0;
        if_addr = 32'h0000_0060;
        check("flush_still_busy", mem_req, 1);
        check("flush_addr_stable", mem_addr, 32'h0000_0020);
        mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        step();
        mem_ack = 1'b0;
        check("flush_no_valid", if_valid, 0);
        check("flush_rdata_kept", if_rdata, exp_if_rdata);
        check("flush_stall", if_stall, 1);
        step();
        check("refetch_mem_req", mem_req, 1);
        check("refetch_addr", mem_addr, 32'h0000_0060);
        mem_ack = 1'b1; mem_rdata = 32'h0000_0067;
        step();
        mem_ack = 1'b0;
        check("refetch_valid", if_valid, 1);
        check("refetch_rdata", if_rdata, 32'h0000_0067);

        // Flush during the valid cycle: no effect on this or the next fetch.
        if_flush = 1'b1; if_req = 1'b0;
        step();
        if_flush = 1'b0;
        check("vflush_valid_low", if_valid, 0);
        check("vflush_rdata", if_rdata, 32'h0000_0067);
        if_req = 1'b1; if_addr = 32'h0000_0070;
        step();
        check("vflush_next_req", mem_req, 1);
        mem_ack = 1'b1; mem_rdata = 32'h0000_0071;
        step();
        mem_ack = 1'b0;
        check("vflush_next_valid", if_valid, 1);
        check("vflush_next_rdata", if_rdata, 32'h0000_0071);
        if_req = 1'b0;
        step();

        // Flush on the same cycle as the ack.
        if_req = 1'b1; if_addr = 32'h0000_0030;
        step();
        mem_ack = 1'b1; if_flush = 1'b1; mem_rdata = 32'h0000_EEEE;
        step();
        mem_ack = 1'b0; if_flush = 1'b0; if_req = 1'b0;
        check("ackflush_no_valid", if_valid, 0);
        check("ackflush_rdata", if_rdata, 32'h0000_0071);
        check("ackflush_done", mem_req, 0);
        step();
        check("ackflush_no_late_valid", if_valid, 0);

        // Reset in the middle of an LS write.
        ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'hF; ls_addr = 32'h0000_0500; ls_wdata = 32'h0000_1234;
        step();
        check("rstmid_busy", mem_req, 1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("rstmid");
        ls_req = 1'b0; ls_we = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        check("rstmid_no_resume", mem_req, 0);
        run_txn(vecs[4], 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
